// File: rtl/lsu.sv
// lsu: RV32I load/store unit over a single-ported word memory.
// Misaligned halfword and word accesses are serialized one byte per cycle.
`default_nettype none

module lsu #(
  parameter int MEM_AW = 12
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_we,
  input  logic [2:0]        i_req_funct3,
  input  logic [31:0]       i_req_addr,
  input  logic [31:0]       i_req_wdata,
  output logic              o_rsp_valid,
  output logic [31:0]       o_rsp_rdata,
  output logic              o_rsp_err,
  output logic [MEM_AW-1:0] o_mem_addr,
  output logic [31:0]       o_mem_wdata,
  output logic [3:0]        o_mem_bmask,
  output logic              o_mem_wren,
  input  logic [31:0]       i_mem_rdata
);

  localparam int BW = MEM_AW + 2;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_SPLIT  = 2'd2;
  localparam logic [1:0] S_RESP   = 2'd3;

  logic [1:0]    r_state;
  logic          r_live;
  logic          r_we;
  logic [2:0]    r_f3;
  logic [BW-1:0] r_addr;
  logic [31:0]   r_wdata;
  logic [1:0]    r_k;
  logic [31:0]   r_data;
  logic          r_err;

  logic          w_accept;
  logic          w_legal;
  logic          w_single;
  logic          w_last;
  logic          w_in_mem;
  logic [BW-1:0] w_ba;
  logic [1:0]    w_lane;
  logic [3:0]    w_mask;
  logic [31:0]   w_wd;
  logic [7:0]    w_rd_byte;
  logic [15:0]   w_rd_half;
  logic [31:0]   w_ext;
  logic          w_unused_addr;

  assign w_unused_addr = &{1'b0, i_req_addr[31:BW]};

  assign o_req_ready = r_live && (r_state == S_IDLE);
  assign w_accept    = i_req_valid && o_req_ready;

  always_comb begin
    w_legal = 1'b0;
    case (i_req_funct3)
      3'b000, 3'b001, 3'b010: w_legal = 1'b1;
      3'b100, 3'b101:         w_legal = !i_req_we;
      default:                w_legal = 1'b0;
    endcase
  end

  // Naturally aligned accesses fit in one memory word.
  assign w_single = (i_req_funct3[1:0] == 2'b00) ||
                    (i_req_funct3[1:0] == 2'b01 && !i_req_addr[0]) ||
                    (i_req_funct3[1:0] == 2'b10 && i_req_addr[1:0] == 2'b00);

  assign w_last   = r_f3[1] ? (r_k == 2'd3) : (r_k == 2'd1);
  assign w_in_mem = (r_state == S_ACCESS) || (r_state == S_SPLIT);
  assign w_ba     = r_addr + {{(BW-2){1'b0}}, r_k};
  assign w_lane   = w_ba[1:0];

  assign w_rd_byte = i_mem_rdata[{w_lane, 3'b000} +: 8];
  assign w_rd_half = w_lane[1] ? i_mem_rdata[31:16] : i_mem_rdata[15:0];

  always_comb begin
    w_mask = 4'b0000;
    w_wd   = 32'h0;
    if (r_state == S_SPLIT) begin
      // Single bytes always travel in the low lane of the write bus.
      w_mask = 4'b0001 << w_lane;
      w_wd   = {24'h0, r_wdata[{r_k, 3'b000} +: 8]};
    end else begin
      case (r_f3[1:0])
        2'b00: begin
          w_mask = 4'b0001 << w_lane;
          w_wd   = {24'h0, r_wdata[7:0]};
        end
        2'b01: begin
          if (w_lane[1]) begin
            w_mask = 4'b1100;
            w_wd   = {r_wdata[15:0], 16'h0};
          end else begin
            w_mask = 4'b0011;
            w_wd   = {16'h0, r_wdata[15:0]};
          end
        end
        default: begin
          w_mask = 4'b1111;
          w_wd   = r_wdata;
        end
      endcase
    end
  end

  assign o_mem_addr  = w_in_mem ? w_ba[BW-1:2] : '0;
  assign o_mem_bmask = w_in_mem ? w_mask : 4'b0000;
  assign o_mem_wren  = w_in_mem && r_we;
  assign o_mem_wdata = (w_in_mem && r_we) ? w_wd : 32'h0;

  always_comb begin
    w_ext = r_data;
    case (r_f3)
      3'b000:  w_ext = {{24{r_data[7]}}, r_data[7:0]};
      3'b001:  w_ext = {{16{r_data[15]}}, r_data[15:0]};
      3'b100:  w_ext = {24'h0, r_data[7:0]};
      3'b101:  w_ext = {16'h0, r_data[15:0]};
      default: w_ext = r_data;
    endcase
  end

  assign o_rsp_valid = (r_state == S_RESP);
  assign o_rsp_err   = (r_state == S_RESP) && r_err;
  assign o_rsp_rdata = ((r_state == S_RESP) && !r_we && !r_err) ? w_ext : 32'h0;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_live  <= 1'b0;
      r_we    <= 1'b0;
      r_f3    <= 3'b000;
      r_addr  <= '0;
      r_wdata <= 32'h0;
      r_k     <= 2'd0;
      r_data  <= 32'h0;
      r_err   <= 1'b0;
    end else begin
      r_live <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_we    <= i_req_we;
            r_f3    <= i_req_funct3;
            r_addr  <= i_req_addr[BW-1:0];
            r_wdata <= i_req_wdata;
            r_k     <= 2'd0;
            r_data  <= 32'h0;
            r_err   <= !w_legal;
            if (!w_legal)     r_state <= S_RESP;
            else if (w_single) r_state <= S_ACCESS;
            else               r_state <= S_SPLIT;
          end
        end
        S_ACCESS: begin
          if (!r_we) begin
            case (r_f3[1:0])
              2'b00:   r_data <= {24'h0, w_rd_byte};
              2'b01:   r_data <= {16'h0, w_rd_half};
              default: r_data <= i_mem_rdata;
            endcase
          end
          r_state <= S_RESP;
        end
        S_SPLIT: begin
          if (!r_we) r_data[{r_k, 3'b000} +: 8] <= w_rd_byte;
          r_k <= r_k + 2'd1;
          if (w_last) r_state <= S_RESP;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_lsu.sv
// tb_lsu: randomized load/store traffic against a byte-array reference model.
`default_nettype none

module tb_lsu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_f3;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic [11:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic [3:0]  mem_bmask;
  logic        mem_wren;

  always #5 clk = ~clk;

  lsu #(.MEM_AW(12)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_req_we(req_we), .i_req_funct3(req_f3),
    .i_req_addr(req_addr), .i_req_wdata(req_wdata),
    .o_rsp_valid(rsp_valid), .o_rsp_rdata(rsp_rdata), .o_rsp_err(rsp_err),
    .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata), .o_mem_bmask(mem_bmask),
    .o_mem_wren(mem_wren), .i_mem_rdata(mem_rdata)
  );

  // Memory attached to the DUT; byte-mask writes take the byte from wdata[7:0].
  logic [31:0] mem [0:4095];
  assign mem_rdata = mem[mem_addr];

  always @(posedge clk) begin
    if (mem_wren) begin
      case (mem_bmask)
        4'b0001: mem[mem_addr][7:0]   <= mem_wdata[7:0];
        4'b0010: mem[mem_addr][15:8]  <= mem_wdata[7:0];
        4'b0100: mem[mem_addr][23:16] <= mem_wdata[7:0];
        4'b1000: mem[mem_addr][31:24] <= mem_wdata[7:0];
        4'b0011: mem[mem_addr][15:0]  <= mem_wdata[15:0];
        4'b1100: mem[mem_addr][31:16] <= mem_wdata[31:16];
        4'b1111: mem[mem_addr]        <= mem_wdata;
        default: ;
      endcase
    end
  end

  // Reference: flat byte-addressed memory of 2^14 bytes.
  logic [7:0] refm [0:16383];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit is_legal(input bit we, input logic [2:0] f3);
    if (we) return (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2);
    return (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
  endfunction

  function automatic int nbytes(input logic [2:0] f3);
    if (f3[1:0] == 2'd0) return 1;
    if (f3[1:0] == 2'd1) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a);
    logic [31:0] v;
    int nb;
    nb = nbytes(f3);
    v = 32'h0;
    for (int k = 0; k < nb; k++) v = v | (32'(refm[(a + 32'(k)) & 32'h3FFF]) << (8 * k));
    if (f3 == 3'd0 && v[7])  v = v | 32'hFFFF_FF00;
    if (f3 == 3'd1 && v[15]) v = v | 32'hFFFF_0000;
    return v;
  endfunction

  task automatic do_req(input bit we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input bit b2b);
    bit          legal, single;
    int          nb, ncyc, lat, n;
    logic [31:0] e_addr [4];
    logic [31:0] e_mask [4];
    logic [31:0] e_wd   [4];
    logic [31:0] e_rd, ba;

    legal  = is_legal(we, f3);
    nb     = nbytes(f3);
    single = ((a % 32'(nb)) == 0);
    ncyc   = !legal ? 0 : (single ? 1 : nb);
    lat    = ncyc + 1;
    if (single) begin
      e_addr[0] = (a >> 2) & 32'hFFF;
      e_mask[0] = ((32'd1 << nb) - 1) << (a & 3);
      if (!we)          e_wd[0] = 32'h0;
      else if (nb == 1) e_wd[0] = wd & 32'hFF;
      else if (nb == 2) e_wd[0] = (wd & 32'hFFFF) << (8 * (a & 3));
      else              e_wd[0] = wd;
    end else begin
      for (int k = 0; k < nb; k++) begin
        ba        = a + 32'(k);
        e_addr[k] = (ba >> 2) & 32'hFFF;
        e_mask[k] = 32'd1 << (ba & 3);
        e_wd[k]   = we ? ((wd >> (8 * k)) & 32'hFF) : 32'h0;
      end
    end
    e_rd = (legal && !we) ? ref_load(f3, a) : 32'h0;

    req_valid = 1'b1; req_we = we; req_f3 = f3; req_addr = a; req_wdata = wd;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      check("accept_timeout", 32'd0, 32'd1);
      req_valid = 1'b0;
      return;
    end
    if (b2b) check("b2b_wait", 32'(n), 32'd1);
    @(posedge clk);
    @(negedge clk);
    // Junk on the request bus while busy must be ignored.
    req_valid = 1'($urandom); req_we = 1'($urandom); req_f3 = 3'($urandom);
    req_addr = $urandom; req_wdata = $urandom;
    for (int c = 1; c <= lat; c++) begin
      if (c < lat) begin
        check("mem_addr",  32'(mem_addr),  e_addr[c-1]);
        check("mem_bmask", 32'(mem_bmask), e_mask[c-1]);
        check("mem_wdata", mem_wdata,      e_wd[c-1]);
        check("mem_wren",  32'(mem_wren),  32'(we));
        check("rsp_early", 32'(rsp_valid), 32'd0);
        check("busy_rdy",  32'(req_ready), 32'd0);
        @(negedge clk);
      end else begin
        check("rsp_valid", 32'(rsp_valid), 32'd1);
        check("rsp_err",   32'(rsp_err),   32'(!legal));
        check("rsp_rdata", rsp_rdata,      e_rd);
        check("resp_mask", 32'(mem_bmask), 32'd0);
        check("resp_wren", 32'(mem_wren),  32'd0);
      end
    end
    if (legal && we)
      for (int k = 0; k < nb; k++) refm[(a + 32'(k)) & 32'h3FFF] = wd[8*k +: 8];
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_rdy"},   32'(req_ready), 32'd0);
    check({tag, "_rsp"},   32'(rsp_valid), 32'd0);
    check({tag, "_err"},   32'(rsp_err),   32'd0);
    check({tag, "_rdata"}, rsp_rdata,      32'd0);
    check({tag, "_maddr"}, 32'(mem_addr),  32'd0);
    check({tag, "_mask"},  32'(mem_bmask), 32'd0);
    check({tag, "_wren"},  32'(mem_wren),  32'd0);
    check({tag, "_wdata"}, mem_wdata,      32'd0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, r;
    bit          we;
    logic [2:0]  f3;

    for (int i = 0; i < 4096; i++) begin
      mem[i] = $urandom;
      for (int b = 0; b < 4; b++) refm[4*i + b] = mem[i][8*b +: 8];
    end
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_f3 = 3'd0;
    req_addr = 32'h0; req_wdata = 32'h0;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst_n = 1'b1;
    #1 check("rdy_pre_edge", 32'(req_ready), 32'd0);
    @(negedge clk);
    check("rdy_post_rst", 32'(req_ready), 32'd1);

    do_req(1'b1, 3'd2, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0);
    do_req(1'b0, 3'd2, 32'h0000_0010, 32'h0, 1'b1);
    do_req(1'b1, 3'd1, 32'h0000_0012, 32'h0000_A5C3, 1'b1);
    do_req(1'b0, 3'd1, 32'h0000_0012, 32'h0, 1'b1);
    do_req(1'b0, 3'd5, 32'h0000_0012, 32'h0, 1'b1);
    do_req(1'b1, 3'd2, 32'h0000_0007, 32'h4433_2211, 1'b1);
    do_req(1'b0, 3'd2, 32'h0000_0007, 32'h0, 1'b1);
    do_req(1'b0, 3'd3, 32'h0000_0020, 32'h0, 1'b1);
    do_req(1'b1, 3'd5, 32'h0000_0020, 32'h1234_5678, 1'b1);
    do_req(1'b1, 3'd1, 32'h0000_3FFF, 32'h0000_9A7E, 1'b1);
    do_req(1'b0, 3'd5, 32'h0000_3FFF, 32'h0, 1'b1);
    do_req(1'b0, 3'd0, 32'h0000_3FFF, 32'h0, 1'b1);

    for (int t = 0; t < 250; t++) begin
      we = 1'($urandom);
      f3 = 3'($urandom);
      r  = $urandom;
      a  = ($urandom & 32'hFFFF_C000) | ((r[8]) ? (32'h3FF8 + (r & 7)) : (r & 32'h3F));
      do_req(we, f3, a, $urandom, 1'b1);
    end

    // Reset in the middle of a misaligned store.
    req_valid = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_f3 = 3'd2;
    req_addr = 32'h0000_0107; req_wdata = 32'hA1B2_C3D4;
    check("split_rdy", 32'(req_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check("split_c1_mask", 32'(mem_bmask), 32'h8);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1 check_idle_outputs("abort");
    @(negedge clk);
    check("abort_rsp", 32'(rsp_valid), 32'd0);
    rst_n = 1'b1;
    #1 check("abort_rdy0", 32'(req_ready), 32'd0);
    @(negedge clk);
    check("abort_rdy1", 32'(req_ready), 32'd1);
    check("abort_rsp2", 32'(rsp_valid), 32'd0);
    refm[32'h107] = 8'hD4;
    do_req(1'b0, 3'd4, 32'h0000_0107, 32'h0, 1'b0);
    do_req(1'b0, 3'd4, 32'h0000_0108, 32'h0, 1'b1);
    do_req(1'b0, 3'd2, 32'h0000_0104, 32'h0, 1'b1);

    req_valid = 1'b0;
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
